// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM encoding,
// default operand width and the iteration-counter width helper.
package seq_divider_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        SUB   = 2'b10,
        DONE  = 2'b11
    } div_state_t;

    // Counter must hold N-1; keep at least one bit for tiny N.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_divider_down_counter.sv
// Loadable down counter with a zero flag; counts the remaining quotient bits.
module down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider: one quotient bit per SHIFT/SUB pair,
// results registered on entry to DONE so they are valid while done is high.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = cnt_width(N);

    div_state_t   state_reg, state_next;
    logic [N:0]   a_reg;
    logic [N-1:0] q_reg;
    logic [N-1:0] m_reg;
    logic [N-1:0] quotient_reg;
    logic [N-1:0] remainder_reg;
    logic         div_zero_reg;

    logic [N:0]   diff;
    logic         fits;
    logic [N-1:0] q_final;
    logic         cnt_load;
    logic         cnt_dec;
    logic         cnt_zero;

    // Borrow out of the (N+1)-bit subtract decides the quotient bit.
    assign diff = a_reg - {1'b0, m_reg};
    assign fits = ~diff[N];

    always_comb begin
        q_final    = q_reg;
        q_final[0] = fits;
    end

    down_counter #(
        .W(CW)
    ) u_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .load       (cnt_load),
        .load_value (CW'(N - 1)),
        .en         (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cnt_load   = 1'b1;
                    state_next = (divisor == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: state_next = SUB;
            SUB: begin
                if (cnt_zero) begin
                    state_next = DONE;
                end else begin
                    cnt_dec    = 1'b1;
                    state_next = SHIFT;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg         <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg        <= '0;
                        q_reg        <= dividend;
                        m_reg        <= divisor;
                        div_zero_reg <= (divisor == '0);
                        // Divide-by-zero skips iteration; publish the fixed result now.
                        if (divisor == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                        end
                    end
                end
                SHIFT: begin
                    {a_reg, q_reg} <= {a_reg[N-1:0], q_reg, 1'b0};
                end
                SUB: begin
                    if (fits) begin
                        a_reg    <= diff;
                        q_reg[0] <= 1'b1;
                    end
                    if (cnt_zero) begin
                        quotient_reg  <= q_final;
                        remainder_reg <= fits ? diff[N-1:0] : a_reg[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_zero  = div_zero_reg;
    assign done      = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic (/ and %) reference model.
module tb_seq_divider;

    localparam int N       = 4;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;

    int compared   = 0;
    int mismatched = 0;
    int done_count = 0;

    logic [N-1:0] last_q = '0;
    logic [N-1:0] last_r = '0;

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_count++;
    end

    // One complete operation started from an IDLE cycle; returns in the IDLE
    // cycle after DONE so the next call is back-to-back.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] eq, er;
        logic         ez, hold_ok;
        int           lat, exp_lat, dc0;
        eq      = (b == 0) ? {N{1'b1}} : N'(a / b);
        er      = (b == 0) ? a : N'(a % b);
        ez      = (b == 0);
        exp_lat = (b == 0) ? 1 : 2 * N + 1;
        dc0     = done_count;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        lat      = 1;
        hold_ok  = 1'b1;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (quotient !== last_q || remainder !== last_r) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        compared++;
        if (done !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout %0d/%0d: no done within %0d cycles", a, b, TIMEOUT);
        end
        compared++;
        if (lat !== exp_lat) begin
            mismatched++;
            $display("FAIL latency %0d/%0d: got %0d expected %0d", a, b, lat, exp_lat);
        end
        compared++;
        if (quotient !== eq) begin
            mismatched++;
            $display("FAIL quotient %0d/%0d: got %0d expected %0d", a, b, quotient, eq);
        end
        compared++;
        if (remainder !== er) begin
            mismatched++;
            $display("FAIL remainder %0d/%0d: got %0d expected %0d", a, b, remainder, er);
        end
        compared++;
        if (div_zero !== ez) begin
            mismatched++;
            $display("FAIL div_zero %0d/%0d: got %b expected %b", a, b, div_zero, ez);
        end
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_in_done %0d/%0d: got %b expected 1", a, b, busy);
        end
        compared++;
        if (hold_ok !== 1'b1) begin
            mismatched++;
            $display("FAIL hold %0d/%0d: outputs changed before done (prev q=%0d r=%0d)",
                     a, b, last_q, last_r);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || (done_count - dc0) !== 1) begin
            mismatched++;
            $display("FAIL done_pulse %0d/%0d: got %0d pulses (done now %b) expected 1",
                     a, b, done_count - dc0, done);
        end
        $display("op %0d/%0d -> q=%0d r=%0d dz=%b lat=%0d", a, b, quotient, remainder,
                 div_zero, lat);
        last_q = eq;
        last_r = er;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        compared++;
        if ({quotient, remainder, busy, done, div_zero} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b expected all 0",
                     quotient, remainder, busy, done, div_zero);
        end
        resetn = 1'b1;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0/0", busy, done);
        end
        last_q = '0;
        last_r = '0;
        $display("reset checked");
    endtask

    task automatic test_directed();
        run_op(4'd13, 4'd4);
        run_op(4'd15, 4'd1);
        run_op(4'd3,  4'd7);
        run_op(4'd0,  4'd5);
        run_op(4'd15, 4'd15);
    endtask

    task automatic test_div_zero();
        run_op(4'd9, 4'd0);
        run_op(4'd6, 4'd3);
    endtask

    task automatic test_start_while_busy();
        int lat, dc0;
        dc0      = done_count;
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (lat == 3) begin
                start    = 1'b1;
                dividend = 4'd1;
                divisor  = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        compared++;
        if (lat !== 2 * N + 1 || quotient !== 4'd3 || remainder !== 4'd1) begin
            mismatched++;
            $display("FAIL busy_start: got lat=%0d q=%0d r=%0d expected lat=9 q=3 r=1",
                     lat, quotient, remainder);
        end
        repeat (2 * N + 4) @(negedge clk);
        compared++;
        if ((done_count - dc0) !== 1) begin
            mismatched++;
            $display("FAIL busy_start_pulses: got %0d done pulses expected 1", done_count - dc0);
        end
        $display("start-while-busy: q=%0d r=%0d pulses=%0d", quotient, remainder, done_count - dc0);
        last_q = 4'd3;
        last_r = 4'd1;
        run_op(N'($urandom_range(15, 0)), N'($urandom_range(15, 1)));
    endtask

    task automatic test_reset_mid_op();
        int lat, dc0;
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (lat < 5) begin
            @(negedge clk);
            lat++;
        end
        dc0    = done_count;
        resetn = 1'b0;
        #1;
        compared++;
        if ({quotient, remainder, busy, done, div_zero} !== '0) begin
            mismatched++;
            $display("FAIL midop_reset: got q=%0d r=%0d busy=%b done=%b dz=%b expected all 0",
                     quotient, remainder, busy, done, div_zero);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2 * N + 4) @(negedge clk);
        compared++;
        if ((done_count - dc0) !== 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midop_no_done: got %0d pulses busy=%b expected 0 pulses busy=0",
                     done_count - dc0, busy);
        end
        $display("reset mid-operation: pulses=%0d", done_count - dc0);
        last_q = '0;
        last_r = '0;
        run_op(4'd10, 4'd3);
    endtask

    task automatic test_back_to_back();
        int order [256];
        int j, tmp;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            run_op(N'(order[i] >> 4), N'(order[i] & 15));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
